dwt_sym_ext_tx: RTL
===================

# dwt_sym_ext_tx

Line sequencer that feeds the 1-D lifting processing unit from a raster sample stream. It accepts one sample per beat, buffers each line in a ping-pong even/odd store, and re-emits the line as `{odd, even}` pairs with whole-sample symmetric extension (two mirrored pairs before and after the body). It is the transmitter side of the processing unit's `s_*` stream and sits between the tile reader and `ProcessingUnit1D`.

## Interface
- `DataWidth`, 24: sample width (fixed-point, two's complement).
- `MaximumSideSize`, 32: maximum line length N in samples; even, ≥ 6.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset; one clock; reset is asynchronous and active-low.
- `s_ready_o` out 1: input beat accepted when `s_valid_i & s_ready_o`.
- `s_valid_i` in 1: input sample valid.
- `s_sof_i` in 1: first sample of frame.
- `s_eol_i` in 1: last sample of line.
- `s_data_i` in DataWidth: sample.
- `m_ready_i` in 1: downstream ready.
- `m_valid_o` out 1: output pair valid.
- `m_sof_o` out 1: first pair of a line whose first sample carried sof.
- `m_eol_o` out 1: last pair of a line.
- `m_data_o` out 2*DataWidth: `{odd, even}`; odd in [2W-1:W], even in [W-1:0].
- `err_o` out 1: one-cycle pulse, line dropped.

## Operation
- Write side: column counter c; sample with c even → even store[c/2], odd → odd store[c/2]. On eol: N = c+1; if N odd, N < 6 or N > MaximumSideSize → drop line, pulse `err_o`, bank stays empty. Overflow (c reaches MaximumSideSize without eol) → discard samples until eol, then drop + `err_o`.
- Two banks (ping-pong), each with full flag, N, sof flag. Write bank toggles on each accepted valid line. `s_ready_o` = write bank not full.
- Read FSM: IDLE → PRE0 → PRE1 → BODY → POST0 → POST1 → IDLE (or PRE0 if other bank full). Pairs (even idx, odd idx) in half-sample index: PRE0 (2,1) = x4,x3; PRE1 (1,0) = x2,x1; BODY k=0..N/2-1 (k,k); POST0 (N/2-1, N/2-2) = x[N-2],x[N-3]; POST1 (N/2-2, N/2-3) = x[N-4],x[N-5]. N/2+4 beats per line.
- `m_sof_o` on PRE0 if bank sof flag set; `m_eol_o` on POST1 only. Bank freed when POST1 beat accepted.
- Data passed unmodified, no arithmetic.

## Timing
- Reset: `s_ready_o`=0 during reset, 1 the first cycle after release; `m_valid_o`, `m_sof_o`, `m_eol_o`, `err_o`, `m_data_o` = 0; both banks empty, FSM IDLE, counters 0.
- Output registered; stores read combinationally (flop arrays). eol accepted at edge E with read side idle → `m_valid_o` high after edge E+1.
- AXI-stream rules: `m_valid_o`/data/flags held stable while `m_valid_o & !m_ready_i`; no valid drop without handshake.
- Full throughput: continuous 1 pair/cycle within a line; back-to-back lines with no bubble if next bank full when POST1 accepted.
- Input stalls only when both banks full; write into bank freed on the same edge as POST1 acceptance is allowed in the next cycle.
- Reset mid-line (either side): all state cleared asynchronously, partial lines discarded.
- `s_sof_i` mid-line: latched only at c=0; ignored elsewhere.

## Structure
- Shared package `dwt97_pkg`: `coeff_t` sample typedef, `pair_t` `{odd, even}` packed struct, read-FSM state enum.
- One sub-module natural: `sym_ext_bank` (one even/odd store pair + full/N/sof flags, one write port, two combinational read ports); instantiated twice.

## Test plan
- Line 0..15 (x_i = i·65536), sof on x0 → 12 pairs: (4,3),(2,1),(0,1),(2,3)…(14,15),(14,13),(12,11) ×65536; sof on pair 0, eol on pair 11.
- 16 lines back-to-back, `m_ready_i`=1 → 192 pairs, no gaps after first line; sof only on first line's PRE0.
- Random `m_ready_i` (50%) → identical pair sequence, data stable under stall; `s_ready_o` low only when both banks full.
- N=6 line → 7 pairs: (4,3),(2,1),(0,1),(2,3),(4,5),(4,3),(2,1).
- N=5 and N=4 lines → `err_o` one pulse each, no output; following N=8 line emitted correctly.
- `rst_ni` low mid-BODY → outputs 0 immediately; next line after release emitted from PRE0 correctly.

Source files
------------

// File: rtl/dwt97_pkg.sv
// Shared types for the DWT 9/7 line path: sample, {odd, even} pair and read-sequencer states.
package dwt97_pkg;

    localparam int unsigned CoeffWidth = 24;

    typedef logic signed [CoeffWidth-1:0] coeff_t;

    typedef struct packed {
        coeff_t odd;
        coeff_t even;
    } pair_t;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_PRE0,
        RD_PRE1,
        RD_BODY,
        RD_POST0,
        RD_POST1
    } rd_state_e;

endpackage

// File: rtl/sym_ext_bank.sv
// One line buffer: even/odd sample stores with full/length/sof flags.
// Single write port, combinational read of one even and one odd entry.
module sym_ext_bank
    import dwt97_pkg::*;
#(
    parameter int unsigned  DataWidth       = 24,
    parameter int unsigned  MaximumSideSize = 32,
    localparam int unsigned Depth           = MaximumSideSize / 2,
    localparam int unsigned AddrWidth       = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned HalfWidth       = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wr_en,
    input  logic                 wr_odd,
    input  logic [AddrWidth-1:0] wr_addr,
    input  logic [DataWidth-1:0] wr_data,
    input  logic                 commit,
    input  logic [HalfWidth-1:0] commit_half,
    input  logic                 commit_sof,
    input  logic                 clear,
    input  logic [AddrWidth-1:0] rd_even_addr,
    input  logic [AddrWidth-1:0] rd_odd_addr,
    output logic [DataWidth-1:0] rd_even_data_c,
    output logic [DataWidth-1:0] rd_odd_data_c,
    output logic                 full,
    output logic [HalfWidth-1:0] half,
    output logic                 sof
);

    logic [DataWidth-1:0] even_mem [Depth];
    logic [DataWidth-1:0] odd_mem  [Depth];

    // Sample stores carry no reset; a bank is only read while its full flag is set.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            if (wr_odd) begin
                odd_mem[wr_addr] <= wr_data;
            end else begin
                even_mem[wr_addr] <= wr_data;
            end
        end
    end

    assign rd_even_data_c = even_mem[rd_even_addr];
    assign rd_odd_data_c  = odd_mem[rd_odd_addr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full <= 1'b0;
            half <= '0;
            sof  <= 1'b0;
        end else if (commit) begin
            full <= 1'b1;
            half <= commit_half;
            sof  <= commit_sof;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/dwt_sym_ext_tx.sv
// Raster-to-pair line sequencer: ping-pong line buffers re-emitted as {odd, even}
// pairs with two mirrored pairs of whole-sample symmetric extension on each side.
module dwt_sym_ext_tx
    import dwt97_pkg::*;
#(
    parameter int unsigned DataWidth       = 24,
    parameter int unsigned MaximumSideSize = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    output logic                   s_ready_o,
    input  logic                   s_valid_i,
    input  logic                   s_sof_i,
    input  logic                   s_eol_i,
    input  logic [DataWidth-1:0]   s_data_i,
    input  logic                   m_ready_i,
    output logic                   m_valid_o,
    output logic                   m_sof_o,
    output logic                   m_eol_o,
    output logic [2*DataWidth-1:0] m_data_o,
    output logic                   err_o
);

    localparam int unsigned Depth     = MaximumSideSize / 2;
    localparam int unsigned AddrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned HalfWidth = $clog2(Depth + 1);
    localparam int unsigned ColWidth  = $clog2(MaximumSideSize + 1);
    localparam int unsigned MinLen    = 6;

    // Bank-side signals
    logic [1:0]           wr_en;
    logic [1:0]           commit;
    logic [1:0]           clear;
    logic [1:0]           full;
    logic [1:0]           full_n;
    logic [1:0]           bank_sof;
    logic [HalfWidth-1:0] bank_half  [2];
    logic [DataWidth-1:0] even_rd    [2];
    logic [DataWidth-1:0] odd_rd     [2];
    logic [AddrWidth-1:0] rd_even_addr;
    logic [AddrWidth-1:0] rd_odd_addr;

    // Write side
    logic                wr_bank;
    logic                wr_bank_n;
    logic [ColWidth-1:0] col;
    logic [ColWidth-1:0] line_len;
    logic                sof_lat;
    logic                ready_q;
    logic                err_q;
    logic                accept;
    logic                col_in_range;
    logic                line_ok;
    logic                line_end;
    logic                line_commit;
    logic                first_sof;

    // Read side
    rd_state_e            st;
    rd_state_e            ld_state;
    logic                 rd_bank;
    logic                 ld_bank;
    logic [AddrWidth-1:0] k;
    logic [AddrWidth-1:0] ld_k;
    logic [HalfWidth-1:0] cur_half;
    logic [HalfWidth-1:0] ld_half;
    logic                 adv;
    logic                 load;
    logic                 free;
    logic                 m_valid_q;
    logic                 m_sof_q;
    logic                 m_eol_q;
    logic [2*DataWidth-1:0] m_data_q;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        sym_ext_bank #(
            .DataWidth      (DataWidth),
            .MaximumSideSize(MaximumSideSize)
        ) u_bank (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .wr_en         (wr_en[b]),
            .wr_odd        (col[0]),
            .wr_addr       (AddrWidth'(col >> 1)),
            .wr_data       (s_data_i),
            .commit        (commit[b]),
            .commit_half   (HalfWidth'(line_len >> 1)),
            .commit_sof    (first_sof),
            .clear         (clear[b]),
            .rd_even_addr  (rd_even_addr),
            .rd_odd_addr   (rd_odd_addr),
            .rd_even_data_c(even_rd[b]),
            .rd_odd_data_c (odd_rd[b]),
            .full          (full[b]),
            .half          (bank_half[b]),
            .sof           (bank_sof[b])
        );
    end

    // Read sequencer next state: which beat (if any) goes into the output register.
    always_comb begin
        adv      = ~m_valid_q | m_ready_i;
        load     = 1'b0;
        free     = 1'b0;
        ld_state = st;
        ld_bank  = rd_bank;
        ld_k     = k;
        cur_half = bank_half[rd_bank];
        unique case (st)
            RD_IDLE: begin
                if (full[rd_bank]) begin
                    load     = 1'b1;
                    ld_state = RD_PRE0;
                end
            end
            RD_PRE0: begin
                if (adv) begin
                    load     = 1'b1;
                    ld_state = RD_PRE1;
                end
            end
            RD_PRE1: begin
                if (adv) begin
                    load     = 1'b1;
                    ld_state = RD_BODY;
                    ld_k     = '0;
                end
            end
            RD_BODY: begin
                if (adv) begin
                    load = 1'b1;
                    if (k == AddrWidth'(cur_half - HalfWidth'(1))) begin
                        ld_state = RD_POST0;
                    end else begin
                        ld_k = k + AddrWidth'(1);
                    end
                end
            end
            RD_POST0: begin
                if (adv) begin
                    load     = 1'b1;
                    ld_state = RD_POST1;
                end
            end
            RD_POST1: begin
                // Last beat of the line accepted: release the bank and chain straight
                // into the other one if it already holds a line.
                if (adv) begin
                    free    = 1'b1;
                    ld_bank = ~rd_bank;
                    if (full[~rd_bank]) begin
                        load     = 1'b1;
                        ld_state = RD_PRE0;
                    end else begin
                        ld_state = RD_IDLE;
                    end
                end
            end
            default: ld_state = RD_IDLE;
        endcase

        ld_half = bank_half[ld_bank];
        unique case (ld_state)
            RD_PRE0: begin
                rd_even_addr = AddrWidth'(2);
                rd_odd_addr  = AddrWidth'(1);
            end
            RD_PRE1: begin
                rd_even_addr = AddrWidth'(1);
                rd_odd_addr  = AddrWidth'(0);
            end
            RD_BODY: begin
                rd_even_addr = ld_k;
                rd_odd_addr  = ld_k;
            end
            RD_POST0: begin
                rd_even_addr = AddrWidth'(ld_half - HalfWidth'(1));
                rd_odd_addr  = AddrWidth'(ld_half - HalfWidth'(2));
            end
            RD_POST1: begin
                rd_even_addr = AddrWidth'(ld_half - HalfWidth'(2));
                rd_odd_addr  = AddrWidth'(ld_half - HalfWidth'(3));
            end
            default: begin
                rd_even_addr = '0;
                rd_odd_addr  = '0;
            end
        endcase
    end

    // Write-side decode: column position, line validation and bank flag next state.
    always_comb begin
        accept       = s_valid_i & ready_q;
        col_in_range = col < ColWidth'(MaximumSideSize);
        line_len     = col + ColWidth'(1);
        line_ok      = col_in_range && !line_len[0] && (line_len >= ColWidth'(MinLen));
        line_end     = accept & s_eol_i;
        line_commit  = line_end & line_ok;
        first_sof    = (col == '0) ? s_sof_i : sof_lat;
        wr_bank_n    = wr_bank ^ line_commit;
        for (int b = 0; b < 2; b++) begin
            wr_en[b]  = accept & col_in_range & (wr_bank == 1'(b));
            commit[b] = line_commit & (wr_bank == 1'(b));
            clear[b]  = free & (rd_bank == 1'(b));
            full_n[b] = (full[b] & ~clear[b]) | commit[b];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_bank <= 1'b0;
            col     <= '0;
            sof_lat <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= ~full_n[wr_bank_n];
            err_q   <= line_end & ~line_ok;
            wr_bank <= wr_bank_n;
            if (accept) begin
                if (col == '0) begin
                    sof_lat <= s_sof_i;
                end
                // Column saturates at the maximum; the line is then dropped at its eol.
                if (s_eol_i) begin
                    col <= '0;
                end else if (col_in_range) begin
                    col <= col + ColWidth'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st        <= RD_IDLE;
            rd_bank   <= 1'b0;
            k         <= '0;
            m_valid_q <= 1'b0;
            m_sof_q   <= 1'b0;
            m_eol_q   <= 1'b0;
            m_data_q  <= '0;
        end else if (adv) begin
            st        <= ld_state;
            rd_bank   <= ld_bank;
            k         <= ld_k;
            m_valid_q <= load;
            m_sof_q   <= load & (ld_state == RD_PRE0) & bank_sof[ld_bank];
            m_eol_q   <= load & (ld_state == RD_POST1);
            m_data_q  <= load ? {odd_rd[ld_bank], even_rd[ld_bank]} : '0;
        end
    end

    assign s_ready_o = ready_q;
    assign m_valid_o = m_valid_q;
    assign m_sof_o   = m_sof_q;
    assign m_eol_o   = m_eol_q;
    assign m_data_o  = m_data_q;
    assign err_o     = err_q;

endmodule
